ahb2wb_bridge: RTL and testbench



---
 rtl/ahb2wb_pkg.sv | 29 ++
 rtl/ahb2wb_sel_decode.sv | 32 +++
 rtl/ahb2wb_bridge.sv | 148 ++++++++++++++
 tb/tb_ahb2wb_bridge.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb2wb_pkg.sv
// Shared encodings and state type for the AHB-Lite to Wishbone bridge.
package ahb2wb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StWait,
        StErr1,
        StErr2
    } ahb2wb_state_t;

    function automatic int unsigned size_bytes(input logic [2:0] hsize);
        return 32'd1 << hsize;
    endfunction

endpackage

// File: rtl/ahb2wb_sel_decode.sv
// Combinational hsize/address-offset to Wishbone byte-lane select, with an
// illegal flag for oversize or misaligned transfers.
module ahb2wb_sel_decode
    import ahb2wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned NB = DATA_WIDTH / 8,
    localparam int unsigned OW = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic [2:0]    hsize,
    input  logic [OW-1:0] offset,
    output logic [NB-1:0] sel,
    output logic          illegal
);

    always_comb begin
        int unsigned nbytes;
        int unsigned off;
        sel     = '0;
        illegal = 1'b0;
        nbytes  = size_bytes(hsize);
        off     = (NB > 1) ? 32'(offset) : 32'd0;
        if ((nbytes * 8 > DATA_WIDTH) || ((off & (nbytes - 1)) != 0)) begin
            illegal = 1'b1;
        end else begin
            for (int unsigned i = 0; i < NB; i++) begin
                sel[i] = (i >= off) && (i < off + nbytes);
            end
        end
    end

endmodule

// File: rtl/ahb2wb_bridge.sv
// AHB-Lite slave to Wishbone classic master bridge with wait states and ERROR mapping.
// Define AHB2WB_TIMEOUT_EN to abort Wishbone cycles after TIMEOUT_CYCLES wait cycles.
module ahb2wb_bridge
    import ahb2wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    hclk,
    input  logic                    hreset,
    input  logic                    hsel,
    input  logic [ADDR_WIDTH-1:0]   haddr,
    input  logic [1:0]              htrans,
    input  logic                    hwrite,
    input  logic [2:0]              hsize,
    input  logic [2:0]              hburst,
    input  logic [DATA_WIDTH-1:0]   hwdata,
    input  logic                    hreadyin,
    output logic [DATA_WIDTH-1:0]   hrdata,
    output logic [1:0]              hresp,
    output logic                    hready,
    output logic                    wb_clk,
    output logic                    wb_rst,
    output logic [ADDR_WIDTH-1:0]   wb_addr,
    output logic [DATA_WIDTH-1:0]   wb_data_out,
    input  logic [DATA_WIDTH-1:0]   wb_data_in,
    output logic [DATA_WIDTH/8-1:0] wb_sel,
    output logic                    wb_we,
    output logic                    wb_cyc,
    output logic                    wb_stb,
    input  logic                    wb_ack,
    input  logic                    wb_err
);

    localparam int unsigned NB = DATA_WIDTH / 8;
    localparam int unsigned OW = (NB > 1) ? $clog2(NB) : 1;

    ahb2wb_state_t state;
    logic          accept;
    logic [NB-1:0] dec_sel;
    logic          dec_illegal;
    logic          unused_inputs;

    assign wb_clk = hclk;
    assign wb_rst = hreset;

    // Bursts are treated beat by beat, so only htrans[1] and not hburst matters.
    assign accept        = hsel & htrans[1] & hreadyin & hready;
    assign unused_inputs = ^{hburst, htrans[0]};

    ahb2wb_sel_decode #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sel_decode (
        .hsize   (hsize),
        .offset  (haddr[OW-1:0]),
        .sel     (dec_sel),
        .illegal (dec_illegal)
    );

`ifdef AHB2WB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
    logic [TW-1:0] tmo_cnt;
`endif

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state       <= StIdle;
            hready      <= 1'b1;
            hresp       <= HRESP_OKAY;
            hrdata      <= '0;
            wb_addr     <= '0;
            wb_data_out <= '0;
            wb_sel      <= '0;
            wb_we       <= 1'b0;
            wb_cyc      <= 1'b0;
            wb_stb      <= 1'b0;
`ifdef AHB2WB_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            unique case (state)
                // ERR2 drives hready high, so it doubles as an address phase.
                StIdle, StErr2: begin
                    state  <= StIdle;
                    hready <= 1'b1;
                    hresp  <= HRESP_OKAY;
                    if (accept) begin
                        wb_addr <= haddr;
                        wb_we   <= hwrite;
                        wb_sel  <= dec_sel;
                        hready  <= 1'b0;
                        if (dec_illegal) begin
                            state <= StErr1;
                            hresp <= HRESP_ERROR;
                        end else begin
                            state <= StSetup;
                        end
                    end
                end
                StSetup: begin
                    wb_data_out <= hwdata;
                    wb_cyc      <= 1'b1;
                    wb_stb      <= 1'b1;
                    state       <= StWait;
`ifdef AHB2WB_TIMEOUT_EN
                    tmo_cnt     <= '0;
`endif
                end
                StWait: begin
                    if (wb_err) begin
                        wb_cyc <= 1'b0;
                        wb_stb <= 1'b0;
                        hresp  <= HRESP_ERROR;
                        state  <= StErr1;
                    end else if (wb_ack) begin
                        wb_cyc <= 1'b0;
                        wb_stb <= 1'b0;
                        hready <= 1'b1;
                        if (!wb_we) begin
                            hrdata <= wb_data_in;
                        end
                        state  <= StIdle;
                    end
`ifdef AHB2WB_TIMEOUT_EN
                    else if (tmo_cnt + 1'b1 == TMO_LIMIT) begin
                        wb_cyc <= 1'b0;
                        wb_stb <= 1'b0;
                        hresp  <= HRESP_ERROR;
                        state  <= StErr1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                StErr1: begin
                    hready <= 1'b1;
                    state  <= StErr2;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb2wb_bridge.sv
// Scoreboard bench for ahb2wb_bridge: directed AHB transfers against a scripted Wishbone slave.
module tb_ahb2wb_bridge;
    import ahb2wb_pkg::*;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel;
    logic [15:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hreadyin;
    logic [31:0] hrdata;
    logic [1:0]  hresp;
    logic        hready;
    logic        wb_clk;
    logic        wb_rst;
    logic [15:0] wb_addr;
    logic [31:0] wb_data_out;
    logic [31:0] wb_data_in;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_ack;
    logic        wb_err;

    assign hreadyin = hready;

    ahb2wb_bridge #(
        .ADDR_WIDTH     (16),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .hsel        (hsel),
        .haddr       (haddr),
        .htrans      (htrans),
        .hwrite      (hwrite),
        .hsize       (hsize),
        .hburst      (hburst),
        .hwdata      (hwdata),
        .hreadyin    (hreadyin),
        .hrdata      (hrdata),
        .hresp       (hresp),
        .hready      (hready),
        .wb_clk      (wb_clk),
        .wb_rst      (wb_rst),
        .wb_addr     (wb_addr),
        .wb_data_out (wb_data_out),
        .wb_data_in  (wb_data_in),
        .wb_sel      (wb_sel),
        .wb_we       (wb_we),
        .wb_cyc      (wb_cyc),
        .wb_stb      (wb_stb),
        .wb_ack      (wb_ack),
        .wb_err      (wb_err)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          waits;
    } ahb_exp_t;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } wb_exp_t;

    ahb_exp_t    ahb_q[$];
    wb_exp_t     wb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_hrdata = '0;

    // Scripted slave: ack/err in the given WAIT cycle (1-based, 0 = never).
    int          ack_cycle = 0;
    int          err_cycle = 0;
    logic [31:0] rd_val = '0;
    logic        late_ack = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=missing required=present", name);
    endtask

    initial begin
        int k = 0;
        wb_ack     = 1'b0;
        wb_err     = 1'b0;
        wb_data_in = '0;
        forever begin
            @(negedge hclk);
            if (wb_cyc && wb_stb) k++;
            else k = 0;
            wb_ack     = (wb_cyc && k == ack_cycle) || late_ack;
            wb_err     = wb_cyc && k == err_cycle;
            wb_data_in = rd_val;
        end
    end

    // Monitor: pops expectations when a WB cycle starts and when an AHB data phase ends.
    initial begin
        bit       pending = 1'b0;
        int       waits = 0;
        logic [1:0] prev_hresp = '0;
        logic     prev_cyc = 1'b0;
        ahb_exp_t ea;
        wb_exp_t  ew;
        forever begin
            @(negedge hclk);
            if (hreset) begin
                pending = 1'b0;
            end else begin
                if (wb_cyc && !prev_cyc) begin
                    if (wb_q.size() == 0) begin
                        fail_now("wb_unexpected_cycle");
                    end else begin
                        ew = wb_q.pop_front();
                        chk("wb_stb", 64'(wb_stb), 64'd1);
                        chk("wb_addr", 64'(wb_addr), 64'(ew.addr));
                        chk("wb_we", 64'(wb_we), 64'(ew.we));
                        chk("wb_sel", 64'(wb_sel), 64'(ew.sel));
                        if (ew.we) chk("wb_data_out", 64'(wb_data_out), 64'(ew.wdata));
                    end
                end
                if (pending) begin
                    if (!hready) begin
                        waits++;
                    end else begin
                        pending = 1'b0;
                        if (ahb_q.size() == 0) begin
                            fail_now("ahb_unexpected_completion");
                        end else begin
                            ea = ahb_q.pop_front();
                            chk("hresp", 64'(hresp), 64'(ea.resp));
                            chk("hrdata", 64'(hrdata), 64'(ea.rdata));
                            chk("wait_states", 64'(waits), 64'(ea.waits));
                            if (ea.resp == HRESP_ERROR)
                                chk("err1_hresp", 64'(prev_hresp), 64'(HRESP_ERROR));
                        end
                    end
                end
                if (hsel && htrans[1] && hreadyin && hready) begin
                    pending = 1'b1;
                    waits   = 0;
                end
            end
            prev_hresp = hresp;
            prev_cyc   = wb_cyc;
        end
    end

    task automatic xfer(input logic wr, input logic [15:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input int ack_c, input int err_c,
                        input logic [31:0] rdv, input logic [1:0] eresp, input int ewaits,
                        input logic ewb, input logic [3:0] esel);
        ahb_exp_t ea;
        wb_exp_t  ew;
        int       n;
        ack_cycle = ack_c;
        err_cycle = err_c;
        rd_val    = rdv;
        if (eresp == HRESP_OKAY && !wr) model_hrdata = rdv;
        ea.resp  = eresp;
        ea.rdata = model_hrdata;
        ea.waits = ewaits;
        ahb_q.push_back(ea);
        if (ewb) begin
            ew.addr  = addr;
            ew.we    = wr;
            ew.sel   = esel;
            ew.wdata = wdata;
            wb_q.push_back(ew);
        end
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
        @(posedge hclk);
        #1;
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwdata = wdata;
        n = 0;
        do begin
            @(negedge hclk);
            n++;
        end while (!hready && n < 40);
        if (!hready) fail_now("hready_timeout");
        @(posedge hclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        hreset = 1'b1;
        hsel   = 1'b0;
        haddr  = '0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        hsize  = HSIZE_WORD;
        hburst = 3'd0;
        hwdata = '0;
        repeat (3) @(posedge hclk);
        #1;
        hreset = 1'b0;
        @(negedge hclk);
        chk("rst_hready", 64'(hready), 64'd1);
        chk("rst_hresp", 64'(hresp), 64'd0);
        chk("rst_hrdata", 64'(hrdata), 64'd0);
        chk("rst_wb_cyc", 64'(wb_cyc), 64'd0);
        chk("rst_wb_stb", 64'(wb_stb), 64'd0);
        chk("rst_wb_we", 64'(wb_we), 64'd0);
        chk("rst_wb_sel", 64'(wb_sel), 64'd0);
        chk("rst_wb_addr", 64'(wb_addr), 64'd0);
        chk("rst_wb_data_out", 64'(wb_data_out), 64'd0);
        @(posedge hclk);
        #1;

        // Selected IDLE transfer: zero wait OKAY, no Wishbone activity.
        hsel   = 1'b1;
        htrans = HTRANS_IDLE;
        repeat (2) @(posedge hclk);
        #1;
        hsel = 1'b0;
        chk("idle_hready", 64'(hready), 64'd1);
        chk("idle_wb_cyc", 64'(wb_cyc), 64'd0);

        //   wr    addr      size        wdata         ack err rdata         resp         wt wb sel
        xfer(1'b1, 16'h0004, HSIZE_WORD, 32'hDEADBEEF, 1, 0, 32'h0,        HRESP_OKAY,  2, 1, 4'b1111);
        xfer(1'b0, 16'h0003, HSIZE_BYTE, 32'h0,        4, 0, 32'h11223344, HRESP_OKAY,  5, 1, 4'b1000);
        xfer(1'b1, 16'h0010, HSIZE_WORD, 32'h01020304, 0, 2, 32'h0,        HRESP_ERROR, 4, 1, 4'b1111);
        xfer(1'b0, 16'h0000, HSIZE_DWORD,32'h0,        1, 0, 32'h0,        HRESP_ERROR, 1, 0, 4'b0000);
        xfer(1'b1, 16'h0001, HSIZE_HALF, 32'h0000BEEF, 1, 0, 32'h0,        HRESP_ERROR, 1, 0, 4'b0000);
        xfer(1'b0, 16'h0002, HSIZE_HALF, 32'h0,        2, 0, 32'hCAFEF00D, HRESP_OKAY,  3, 1, 4'b1100);
        xfer(1'b1, 16'h0005, HSIZE_BYTE, 32'h0000AB00, 1, 0, 32'h0,        HRESP_OKAY,  2, 1, 4'b0010);
        xfer(1'b0, 16'h0008, HSIZE_WORD, 32'h0,        1, 1, 32'h99999999, HRESP_ERROR, 3, 1, 4'b1111);
`ifdef AHB2WB_TIMEOUT_EN
        xfer(1'b0, 16'h000C, HSIZE_WORD, 32'h0,        0, 0, 32'h0,        HRESP_ERROR, 6, 1, 4'b1111);
        xfer(1'b0, 16'h000C, HSIZE_WORD, 32'h0,        4, 0, 32'h0BADF00D, HRESP_OKAY,  5, 1, 4'b1111);
`endif

        // Reset mid-WAIT, then a late ack that must be ignored.
        begin
            wb_exp_t ew;
            ack_cycle = 0;
            err_cycle = 0;
            rd_val    = 32'h77777777;
            ew.addr   = 16'h0020;
            ew.we     = 1'b0;
            ew.sel    = 4'b1111;
            ew.wdata  = '0;
            wb_q.push_back(ew);
            hsel   = 1'b1;
            htrans = HTRANS_NONSEQ;
            haddr  = 16'h0020;
            hwrite = 1'b0;
            hsize  = HSIZE_WORD;
            @(posedge hclk);
            #1;
            hsel   = 1'b0;
            htrans = HTRANS_IDLE;
            repeat (3) @(posedge hclk);
            #1;
            chk("pre_reset_wb_cyc", 64'(wb_cyc), 64'd1);
            hreset = 1'b1;
            @(posedge hclk);
            #1;
            hreset   = 1'b0;
            late_ack = 1'b1;
            @(posedge hclk);
            #1;
            late_ack = 1'b0;
            @(negedge hclk);
            model_hrdata = '0;
            chk("post_reset_hready", 64'(hready), 64'd1);
            chk("post_reset_hresp", 64'(hresp), 64'd0);
            chk("post_reset_hrdata", 64'(hrdata), 64'd0);
            chk("post_reset_wb_cyc", 64'(wb_cyc), 64'd0);
            chk("post_reset_wb_stb", 64'(wb_stb), 64'd0);
            chk("post_reset_wb_addr", 64'(wb_addr), 64'd0);
            chk("post_reset_wb_sel", 64'(wb_sel), 64'd0);
            @(posedge hclk);
            #1;
        end

        xfer(1'b0, 16'h0008, HSIZE_WORD, 32'h0, 1, 0, 32'h55AA55AA, HRESP_OKAY, 2, 1, 4'b1111);

        repeat (3) @(posedge hclk);
        chk("ahb_queue_drained", 64'(ahb_q.size()), 64'd0);
        chk("wb_queue_drained", 64'(wb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
